// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and helpers for the registered N-channel selector
package mux_arb_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    // Index width for an n-channel selector, never narrower than one bit
    function automatic int sel_width(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search starting one past ptr, modulo N
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            advance,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic [SELW-1:0] ptr_next
);

    logic found;
    int   idx;

    // First requester after ptr wins; ptr itself is checked last
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = SELW'(idx);
            end
        end
    end

    // Pointer moves to the winner only when its beat is actually taken
    assign ptr_next = (advance && found) ? gnt_idx : ptr;

endmodule

// File: rtl/mux_arb_reg.sv
// rtl/mux_arb_reg.sv - registered N:1 stream selector, round-robin mode under MUX_RR_EN
module mux_arb_reg
    import mux_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SELW-1:0] out_sel
);

    logic            can_load;
    logic            xfer;
    logic [N-1:0]    sel_gnt;
    logic [N-1:0]    grant;
    logic [SELW-1:0] grant_idx;

    assign can_load = !out_valid || out_ready;

    // Explicit select: an out-of-range index never grants anything
    always_comb begin
        sel_gnt = '0;
        if (int'(sel) < N) begin
            sel_gnt[sel] = in_valid[sel];
        end
    end

`ifdef MUX_RR_EN
    logic            rr_mode;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_next;
    logic [N-1:0]    rr_gnt;
    logic [SELW-1:0] rr_idx;

    assign rr_mode = (mode_e'(mode) == MODE_RR);

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req      (in_valid),
        .ptr      (ptr),
        .advance  (xfer && rr_mode),
        .gnt      (rr_gnt),
        .gnt_idx  (rr_idx),
        .ptr_next (ptr_next)
    );

    assign grant     = rr_mode ? rr_gnt : sel_gnt;
    assign grant_idx = rr_mode ? rr_idx : sel;

    // Round-robin pointer; starts at N-1 so channel 0 is searched first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= SELW'(N - 1);
        end else begin
            ptr <= ptr_next;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign grant       = sel_gnt;
    assign grant_idx   = sel;
`endif

    assign in_ready = (rst_n && can_load) ? grant : '0;
    assign xfer     = |(in_valid & in_ready);

    // One-beat output buffer: load on transfer, drain on consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_idx*W +: W];
            out_sel   <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb/tb_mux_arb_reg.sv - directed table and sequence checks for mux_arb_reg
module tb_mux_arb_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sel;

    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic [1:0]  b_sel;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic [1:0]  b_out_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_arb_reg #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    mux_arb_reg #(.N(3), .W(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .sel       (b_sel),
        .mode      (1'b0),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (1'b1),
        .out_sel   (b_out_sel)
    );

    typedef struct {
        logic [1:0] sel;
        logic [3:0] v;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [7:0] e_data;
        logic [1:0] e_sel;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [1:0] rr_exp [9];
    logic [1:0] exp_after_reset;

    initial begin
        tbl[0] = '{2'd2, 4'hF,    1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
        tbl[1] = '{2'd0, 4'hF,    1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[2] = '{2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};
        tbl[3] = '{2'd1, 4'hF,    1'b0, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[4] = '{2'd3, 4'hF,    1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
        tbl[5] = '{2'd3, 4'hF,    1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[6] = '{2'd0, 4'h0,    1'b1, 4'b0000, 1'b0, 8'h44, 2'd3};
        tbl[7] = '{2'd2, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'h33, 2'd2};

        in_data    = 32'h44332211;
        in_valid   = 4'hF;
        sel        = 2'd2;
        mode       = 1'b0;
        out_ready  = 1'b1;
        b_in_data  = 24'h332211;
        b_in_valid = 3'b111;
        b_sel      = 2'd3;
        rst_n      = 1'b0;

        // Reset state with every input valid
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 4'b0000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_sel", out_sel, 2'd0);
        rst_n = 1'b1;

        // Mode 0 table
        for (int i = 0; i < 8; i++) begin
            sel       = tbl[i].sel;
            in_valid  = tbl[i].v;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            step();
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_data);
            chk($sformatf("tbl%0d_out_sel", i), out_sel, tbl[i].e_sel);
        end

        // Backpressure: beat A held while stalled, beat B follows without a gap
        do_reset();
        in_valid  = 4'hF;
        sel       = 2'd1;
        out_ready = 1'b1;
        in_data   = 32'h44335A11;
        step();
        chk("bp_beat_a", out_data, 8'h5A);
        out_ready = 1'b0;
        in_data   = 32'h4433B511;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_stall%0d_ready", i), in_ready, 4'b0000);
            step();
            chk($sformatf("bp_stall%0d_data", i), out_data, 8'h5A);
            chk($sformatf("bp_stall%0d_valid", i), out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 4'b0010);
        step();
        chk("bp_beat_b", out_data, 8'hB5);
        chk("bp_beat_b_valid", out_valid, 1'b1);
        in_data = 32'h44332211;

        // Out-of-range select on a 3-channel instance
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("oor%0d_ready", i), b_in_ready, 3'b000);
            chk($sformatf("oor%0d_valid", i), b_out_valid, 1'b0);
            step();
        end

`ifdef MUX_RR_EN
        // Round robin: all valid, then only ch1 and ch3
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3};
        do_reset();
        mode      = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 5) ? 4'hF : 4'b1010;
            step();
            chk($sformatf("rr%0d_sel", i), out_sel, rr_exp[i]);
        end

        // Stall fairness: ptr frozen while stalled
        in_valid = 4'hF;
        step();
        chk("fair_first", out_sel, 2'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("fair_stall%0d_ready", i), in_ready, 4'b0000);
            step();
            chk($sformatf("fair_stall%0d_sel", i), out_sel, 2'd0);
        end
        out_ready = 1'b1;
        step();
        chk("fair_resume0", out_sel, 2'd1);
        step();
        chk("fair_resume1", out_sel, 2'd2);
        exp_after_reset = 2'd0;
`else
        exp_after_reset = 2'd2;
`endif

        // Reset mid-operation discards the held beat
        mode      = 1'b0;
        sel       = 2'd2;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("mid_loaded", out_data, 8'h33);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_valid", out_valid, 1'b0);
        chk("mid_async_data", out_data, 8'h00);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 4'h0;
        step();
        chk("mid_no_beat", out_valid, 1'b0);
        mode      = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        step();
        chk("mid_first_grant", out_sel, exp_after_reset);
        chk("mid_first_valid", out_valid, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
